// File: rtl/gcd_pkg.sv
// ============================================================================
// Module      : gcd_pkg
// Description : Shared types and constants for the GCD job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 64;
  localparam int TIMER_W     = $clog2(TIMEOUT_DEF + 1);
  localparam int GAP_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  // One counter serves both the RUN timeout and the GAP count, so it must fit either.
  function automatic int cnt_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > GAP_W) ? w : GAP_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_seq_timer.sv
// ============================================================================
// Module      : gcd_seq_timer
// Description : Clearable up-counter with a terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_seq_timer
  import gcd_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

`default_nettype wire

// File: rtl/gcd_job_sequencer.sv
// ============================================================================
// Module      : gcd_job_sequencer
// Description : Feeds operand pairs to a GCD core one at a time with a
//               timeout guard. Define GCD_SEQ_STATS_EN for job/timeout stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GAP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_a,
  input  logic [DATA_W-1:0] job_b,
  output logic              gcd_begin,
  output logic [DATA_W-1:0] gcd_a,
  output logic [DATA_W-1:0] gcd_b,
  input  logic              gcd_complete,
  input  logic [DATA_W-1:0] gcd_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_a,
  output logic [DATA_W-1:0] res_b,
  output logic [DATA_W-1:0] res_gcd,
  output logic              res_timeout
`ifdef GCD_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_jobs,
  output logic [15:0]       stat_timeouts
`endif
);

  localparam int CNT_W = cnt_w(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] gcd_a_q, gcd_a_d;
  logic [DATA_W-1:0] gcd_b_q, gcd_b_d;
  logic [DATA_W-1:0] res_gcd_q, res_gcd_d;
  logic              res_timeout_q, res_timeout_d;

  logic              tmr_clr;
  logic              tmr_en;
  logic [CNT_W-1:0]  tmr_term;
  logic [CNT_W-1:0]  tmr_cnt;
  logic              tmr_tc;

  // Cleared in IDLE/HOLD so it reads zero on the first cycle of RUN and of GAP.
  assign tmr_clr  = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign tmr_en   = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign tmr_term = (state_q == ST_GAP) ? CNT_W'(GAP - 1) : CNT_W'(TIMEOUT - 1);

  gcd_seq_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .cnt   (tmr_cnt),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gcd_a_d       = gcd_a_q;
    gcd_b_d       = gcd_b_q;
    res_gcd_d     = res_gcd_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          gcd_a_d = job_a;
          gcd_b_d = job_b;
          if ((job_a == '0) || (job_b == '0)) begin
            state_d       = ST_HOLD;
            res_gcd_d     = job_a | job_b;
            res_timeout_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A complete on the entry cycle (count still zero) is left over from a previous job.
        if (gcd_complete && (tmr_cnt != '0)) begin
          state_d       = ST_HOLD;
          res_gcd_d     = gcd_result;
          res_timeout_d = 1'b0;
        end else if (tmr_tc) begin
          state_d       = ST_HOLD;
          res_gcd_d     = '0;
          res_timeout_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    job_ready = (state_q == ST_IDLE);
    gcd_begin = (state_q == ST_RUN);
    res_valid = (state_q == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_a_q       <= '0;
      gcd_b_q       <= '0;
      res_gcd_q     <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      gcd_a_q       <= gcd_a_d;
      gcd_b_q       <= gcd_b_d;
      res_gcd_q     <= res_gcd_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign gcd_a       = gcd_a_q;
  assign gcd_b       = gcd_b_q;
  assign res_a       = gcd_a_q;
  assign res_b       = gcd_b_q;
  assign res_gcd     = res_gcd_q;
  assign res_timeout = res_timeout_q;

`ifdef GCD_SEQ_STATS_EN
  logic        res_hs;
  logic [15:0] stat_jobs_q, stat_jobs_d;
  logic [15:0] stat_timeouts_q, stat_timeouts_d;

  assign res_hs = (state_q == ST_HOLD) && res_ready;

  always_comb begin
    stat_jobs_d     = stat_jobs_q;
    stat_timeouts_d = stat_timeouts_q;
    if (res_hs) begin
      if (stat_jobs_q != 16'hFFFF) begin
        stat_jobs_d = stat_jobs_q + 16'd1;
      end
      if (res_timeout_q && (stat_timeouts_q != 16'hFFFF)) begin
        stat_timeouts_d = stat_timeouts_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_jobs_q     <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_jobs_q     <= stat_jobs_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_jobs     = stat_jobs_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_job_sequencer.sv
// ============================================================================
// Module      : tb_gcd_job_sequencer
// Description : Randomised self-checking bench with a behavioural GCD core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_job_sequencer;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [DATA_W-1:0] job_a = '0;
  logic [DATA_W-1:0] job_b = '0;
  logic              gcd_begin;
  logic [DATA_W-1:0] gcd_a;
  logic [DATA_W-1:0] gcd_b;
  logic              gcd_complete = 1'b0;
  logic [DATA_W-1:0] gcd_result = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;
  logic [DATA_W-1:0] res_gcd;
  logic              res_timeout;
`ifdef GCD_SEQ_STATS_EN
  logic [15:0]       stat_jobs;
  logic [15:0]       stat_timeouts;
`endif

  gcd_job_sequencer #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_a        (job_a),
    .job_b        (job_b),
    .gcd_begin    (gcd_begin),
    .gcd_a        (gcd_a),
    .gcd_b        (gcd_b),
    .gcd_complete (gcd_complete),
    .gcd_result   (gcd_result),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_a        (res_a),
    .res_b        (res_b),
    .res_gcd      (res_gcd),
    .res_timeout  (res_timeout)
`ifdef GCD_SEQ_STATS_EN
    ,
    .stat_jobs     (stat_jobs),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int jobs_m = 0;
  int tos_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[7:0];
  endfunction

  // Behavioural core: answers core_lat cycles after it first sees Begin, optionally
  // with a bogus complete on the first cycle, or never.
  int core_lat = 1;
  int core_cnt = 0;
  bit core_never = 1'b0;
  bit core_stale = 1'b0;
  bit core_busy = 1'b0;
  bit begin_seen = 1'b0;

  always @(negedge clk) begin
    if (!gcd_begin) begin
      core_busy    = 1'b0;
      gcd_complete = 1'b0;
    end else begin
      begin_seen = 1'b1;
      if (!core_busy) begin
        core_busy    = 1'b1;
        core_cnt     = core_lat;
        gcd_complete = core_stale;
        gcd_result   = 8'hEE;
      end else if (!core_never) begin
        if (core_cnt > 0) core_cnt--;
        if (core_cnt == 0) begin
          gcd_complete = 1'b1;
          gcd_result   = gcd_ref(gcd_a, gcd_b);
        end else begin
          gcd_complete = 1'b0;
        end
      end else begin
        gcd_complete = 1'b0;
      end
    end
  end

  int low_run = GAP;
  int gap_viol = 0;
  bit prev_begin = 1'b0;

  always @(negedge clk) begin
    if (gcd_begin) begin
      if (!prev_begin && (low_run < GAP)) gap_viol++;
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_begin = gcd_begin;
  end

  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int lat,
                         input bit never, input bit stale, input int hold);
    bit         bypass, to;
    logic [7:0] exp_g;
    int         exp_lat, n;
    bypass  = (a == 0) || (b == 0);
    to      = !bypass && (never || (lat > TIMEOUT - 1));
    exp_g   = bypass ? (a | b) : (to ? 8'd0 : gcd_ref(a, b));
    exp_lat = bypass ? 1 : (to ? TIMEOUT + 1 : lat + 2);
    core_lat   = lat;
    core_never = never;
    core_stale = stale;
    begin_seen = 1'b0;

    n = 0;
    while (!job_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) chk("ready_wait", {31'd0, job_ready}, 32'd1);
    job_valid = 1'b1;
    job_a     = a;
    job_b     = b;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("res_a", res_a, a);
    chk("res_b", res_b, b);
    chk("res_gcd", res_gcd, exp_g);
    chk("res_timeout", {31'd0, res_timeout}, {31'd0, to});
    if (bypass) chk("bypass_begin", {31'd0, begin_seen}, 32'd0);

    for (int i = 0; i < hold; i++) begin
      job_valid = 1'b1;
      job_a     = ~a;
      job_b     = ~b;
      @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_ready", {31'd0, job_ready}, 32'd0);
      chk("hold_gcd", res_gcd, exp_g);
      chk("hold_a", gcd_a, a);
    end
    job_valid = 1'b0;

    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    jobs_m++;
    if (to) tos_m++;
    chk("res_drop", {31'd0, res_valid}, 32'd0);
    n = 1;
    while (!job_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("gap_len", n, GAP + 1);
  endtask

  logic [7:0] b2b_a [5] = '{8'd22, 8'd89, 8'd255, 8'd236, 8'd100};
  logic [7:0] b2b_b [5] = '{8'd77, 8'd23, 8'd25,  8'd136, 8'd120};
  logic [7:0] b2b_g [5] = '{8'd11, 8'd1,  8'd5,   8'd4,   8'd20};

  initial begin
    int         n_hi;
    logic [7:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_job_ready", {31'd0, job_ready}, 32'd1);
    chk("rst_begin", {31'd0, gcd_begin}, 32'd0);
    chk("rst_gcd_a", gcd_a, 0);
    chk("rst_gcd_b", gcd_b, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res", {res_a, res_b, res_gcd, 7'd0, res_timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(8'd78, 8'd24, 3, 1'b0, 1'b0, 0);

    for (int i = 0; i < 5; i++) begin
      chk("b2b_ref", gcd_ref(b2b_a[i], b2b_b[i]), b2b_g[i]);
      run_job(b2b_a[i], b2b_b[i], $urandom_range(1, 8), 1'b0, 1'b1, 0);
    end

    run_job(8'd0, 8'd45, 4, 1'b0, 1'b0, 0);
    run_job(8'd0, 8'd0, 4, 1'b0, 1'b0, 0);
    run_job(8'd50, 8'd15, 1, 1'b1, 1'b0, 0);
    run_job(8'd50, 8'd15, TIMEOUT - 1, 1'b0, 1'b0, 0);
    run_job(8'd12, 8'd18, 5, 1'b0, 1'b0, 10);

    // Abort mid-RUN with an asynchronous reset.
    core_never = 1'b1;
    job_valid  = 1'b1;
    job_a      = 8'd9;
    job_b      = 8'd6;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_begin", {31'd0, gcd_begin}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_begin", {31'd0, gcd_begin}, 32'd0);
    chk("arst_job_ready", {31'd0, job_ready}, 32'd1);
    chk("arst_gcd_a", gcd_a, 0);
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    jobs_m = 0;
    tos_m  = 0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    core_never = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (res_valid) n_hi++;
    end
    chk("post_rst_valid", n_hi, 0);

    run_job(8'd21, 8'd14, 2, 1'b0, 1'b0, 0);
    run_job(8'd36, 8'd48, 6, 1'b0, 1'b0, 1);
    run_job(8'd0, 8'd7, 1, 1'b0, 1'b0, 0);
    run_job(8'd40, 8'd30, 1, 1'b1, 1'b1, 0);
`ifdef GCD_SEQ_STATS_EN
    chk("stat_jobs4", stat_jobs, 4);
    chk("stat_to1", stat_timeouts, 1);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ra = 8'd0;
      if ($urandom_range(0, 7) == 0) rb = 8'd0;
      run_job(ra, rb, $urandom_range(1, 20), ($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

`ifdef GCD_SEQ_STATS_EN
    chk("stat_jobs", stat_jobs, jobs_m);
    chk("stat_timeouts", stat_timeouts, tos_m);
`endif
    chk("gap_before_begin", gap_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
